// File: rtl/rpsc_power_sequencer.sv
// rtl/rpsc_power_sequencer.sv - fan/cathode/grid/anode power-on and HV sequencer
// Drives the active-low stage enables as registered decodes of the next state.
module rpsc_power_sequencer #(
    parameter int TW      = 16,
    parameter int FAN_DLY = 16,
    parameter int CA_WARM = 64,
    parameter int G1_DLY  = 8,
    parameter int G2_DLY  = 8,
    parameter int AN_TMO  = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_ps_on,
    input  logic       i_hv_req,
    input  logic       i_Not_ANY_HV_GO_OFF,
    input  logic       i_Not_AN_HV_Ready,
    input  logic       i_fault_clr,
    output logic       o_Not_FAN_ON,
    output logic       o_Not_CA_ON,
    output logic       o_Not_G1_ON,
    output logic       o_Not_G2_ON,
    output logic       o_Not_Anode_ON,
    output logic [2:0] o_state,
    output logic       o_fault
);

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_FAN   = 3'd1,
        ST_CAW   = 3'd2,
        ST_G1    = 3'd3,
        ST_STBY  = 3'd4,
        ST_G2    = 3'd5,
        ST_ANODE = 3'd6,
        ST_HV    = 3'd7
    } state_t;

    localparam logic [TW-1:0] FAN_LD = TW'(FAN_DLY - 1);
    localparam logic [TW-1:0] CAW_LD = TW'(CA_WARM - 1);
    localparam logic [TW-1:0] G1_LD  = TW'(G1_DLY - 1);
    localparam logic [TW-1:0] G2_LD  = TW'(G2_DLY - 1);
    localparam logic [TW-1:0] AN_LD  = TW'(AN_TMO - 1);
    localparam logic [TW-1:0] ONE    = TW'(1);

    state_t        state, next_state;
    logic [TW-1:0] timer, next_timer;
    logic          timer_done;
    logic          hv_drop;
    logic          set_fault;

    assign timer_done = (timer == '0);
    assign hv_drop    = !i_Not_ANY_HV_GO_OFF || !i_hv_req;

    always_comb begin
        next_state = state;
        next_timer = timer_done ? '0 : timer - ONE;
        set_fault  = 1'b0;
        if (!i_ps_on) begin
            next_state = ST_OFF;
            next_timer = '0;
        end else if ((state == ST_G2 || state == ST_ANODE || state == ST_HV) && hv_drop) begin
            next_state = ST_STBY;
            next_timer = '0;
        end else begin
            case (state)
                ST_OFF: if (!o_fault) begin
                    next_state = ST_FAN;
                    next_timer = FAN_LD;
                end
                ST_FAN: if (timer_done) begin
                    next_state = ST_CAW;
                    next_timer = CAW_LD;
                end
                ST_CAW: if (timer_done) begin
                    next_state = ST_G1;
                    next_timer = G1_LD;
                end
                ST_G1: if (timer_done) begin
                    next_state = ST_STBY;
                    next_timer = '0;
                end
                ST_STBY: if (i_hv_req && i_Not_ANY_HV_GO_OFF && !o_fault) begin
                    next_state = ST_G2;
                    next_timer = G2_LD;
                end
                ST_G2: if (timer_done) begin
                    next_state = ST_ANODE;
                    next_timer = AN_LD;
                end
                ST_ANODE: begin
                    // Ready feedback takes precedence over a timeout landing on the same cycle
                    if (!i_Not_AN_HV_Ready) begin
                        next_state = ST_HV;
                        next_timer = '0;
                    end else if (timer_done) begin
                        next_state = ST_STBY;
                        next_timer = '0;
                        set_fault  = 1'b1;
                    end
                end
                ST_HV: next_timer = '0;
                default: begin
                    next_state = ST_OFF;
                    next_timer = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_OFF;
            timer          <= '0;
            o_fault        <= 1'b0;
            o_Not_FAN_ON   <= 1'b1;
            o_Not_CA_ON    <= 1'b1;
            o_Not_G1_ON    <= 1'b1;
            o_Not_G2_ON    <= 1'b1;
            o_Not_Anode_ON <= 1'b1;
        end else begin
            state          <= next_state;
            timer          <= next_timer;
            o_Not_FAN_ON   <= !(next_state >= ST_FAN);
            o_Not_CA_ON    <= !(next_state >= ST_CAW);
            o_Not_G1_ON    <= !(next_state >= ST_G1);
            o_Not_G2_ON    <= !(next_state >= ST_G2);
            o_Not_Anode_ON <= !(next_state >= ST_ANODE);
            if (set_fault)
                o_fault <= 1'b1;
            else if (i_fault_clr && (state == ST_OFF || state == ST_STBY))
                o_fault <= 1'b0;
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_rpsc_power_sequencer.sv
// tb/tb_rpsc_power_sequencer.sv - scoreboard bench for rpsc_power_sequencer
module tb_rpsc_power_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_ps_on = 1'b0;
    logic       i_hv_req = 1'b0;
    logic       i_Not_ANY_HV_GO_OFF = 1'b1;
    logic       i_Not_AN_HV_Ready = 1'b1;
    logic       i_fault_clr = 1'b0;
    logic       o_Not_FAN_ON, o_Not_CA_ON, o_Not_G1_ON, o_Not_G2_ON, o_Not_Anode_ON;
    logic [2:0] o_state;
    logic       o_fault;

    int errors = 0;
    int checks = 0;
    logic [8:0] sb[$];
    logic [8:0] got, exp_v;

    rpsc_power_sequencer dut (
        .clk(clk), .rst_n(rst_n), .i_ps_on(i_ps_on), .i_hv_req(i_hv_req),
        .i_Not_ANY_HV_GO_OFF(i_Not_ANY_HV_GO_OFF), .i_Not_AN_HV_Ready(i_Not_AN_HV_Ready),
        .i_fault_clr(i_fault_clr), .o_Not_FAN_ON(o_Not_FAN_ON), .o_Not_CA_ON(o_Not_CA_ON),
        .o_Not_G1_ON(o_Not_G1_ON), .o_Not_G2_ON(o_Not_G2_ON), .o_Not_Anode_ON(o_Not_Anode_ON),
        .o_state(o_state), .o_fault(o_fault)
    );

    always #5 clk = ~clk;

    // Reference decode: {state, fault, fan, ca, g1, g2, anode} with active-low enables
    function automatic logic [8:0] model(input logic [2:0] s, input logic f);
        return {s, f, !(s >= 3'd1), !(s >= 3'd2), !(s >= 3'd3), !(s >= 3'd5), !(s >= 3'd6)};
    endfunction

    function automatic logic [8:0] observe();
        return {o_state, o_fault, o_Not_FAN_ON, o_Not_CA_ON, o_Not_G1_ON, o_Not_G2_ON, o_Not_Anode_ON};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sb.push_back(model(3'd0, 1'b0));
        tick(2);
        got = observe(); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL reset_state: got %h expected %h", got, exp_v); end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_powerup();
        int edges[6] = '{1, 16, 17, 81, 88, 89};
        logic [2:0] st[6] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4};
        int last = 0;
        i_ps_on = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sb.push_back(model(st[i], 1'b0));
            tick(edges[i] - last);
            last = edges[i];
            got = observe(); exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) begin errors++; $display("FAIL powerup_edge%0d: got %h expected %h", edges[i], got, exp_v); end
        end
    endtask

    task automatic test_hv_entry();
        int edges[5] = '{1, 8, 9, 13, 14};
        logic [2:0] st[5] = '{3'd5, 3'd5, 3'd6, 3'd6, 3'd7};
        int last = 0;
        i_hv_req = 1'b1;
        i_Not_ANY_HV_GO_OFF = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sb.push_back(model(st[i], 1'b0));
            tick(edges[i] - last);
            last = edges[i];
            got = observe(); exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) begin errors++; $display("FAIL hv_entry_edge%0d: got %h expected %h", edges[i], got, exp_v); end
            if (edges[i] == 13) i_Not_AN_HV_Ready = 1'b0;
        end
    endtask

    task automatic test_trip();
        i_Not_ANY_HV_GO_OFF = 1'b0;
        sb.push_back(model(3'd4, 1'b0));
        tick(1);
        got = observe(); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL trip_to_stby: got %h expected %h", got, exp_v); end
        i_hv_req = 1'b0;
        i_Not_ANY_HV_GO_OFF = 1'b1;
        i_Not_AN_HV_Ready = 1'b1;
        sb.push_back(model(3'd4, 1'b0));
        tick(3);
        got = observe(); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL trip_hold_stby: got %h expected %h", got, exp_v); end
    endtask

    task automatic test_timeout();
        i_hv_req = 1'b1;
        sb.push_back(model(3'd6, 1'b0));
        tick(40);
        got = observe(); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL anode_last_cycle: got %h expected %h", got, exp_v); end
        sb.push_back(model(3'd4, 1'b1));
        tick(1);
        got = observe(); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL anode_timeout: got %h expected %h", got, exp_v); end
        sb.push_back(model(3'd4, 1'b1));
        tick(3);
        got = observe(); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL fault_blocks_g2: got %h expected %h", got, exp_v); end
        i_fault_clr = 1'b1;
        sb.push_back(model(3'd4, 1'b0));
        tick(1);
        i_fault_clr = 1'b0;
        got = observe(); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL fault_clear: got %h expected %h", got, exp_v); end
        sb.push_back(model(3'd5, 1'b0));
        tick(1);
        got = observe(); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL reenter_g2: got %h expected %h", got, exp_v); end
        i_hv_req = 1'b0;
        sb.push_back(model(3'd4, 1'b0));
        tick(1);
        got = observe(); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL hv_req_drop: got %h expected %h", got, exp_v); end
    endtask

    task automatic test_reset_mid_hv();
        i_hv_req = 1'b1;
        tick(9);
        i_Not_AN_HV_Ready = 1'b0;
        sb.push_back(model(3'd7, 1'b0));
        tick(1);
        got = observe(); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL reach_hv: got %h expected %h", got, exp_v); end
        #2;
        rst_n = 1'b0;
        sb.push_back(model(3'd0, 1'b0));
        #1;
        got = observe(); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL async_reset: got %h expected %h", got, exp_v); end
        i_hv_req = 1'b0;
        i_Not_AN_HV_Ready = 1'b1;
        tick(1);
        rst_n = 1'b1;
    endtask

    task automatic test_ps_off_caw();
        i_ps_on = 1'b0;
        tick(2);
        i_ps_on = 1'b1;
        tick(46);
        sb.push_back(model(3'd2, 1'b0));
        got = observe(); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL caw_cycle30: got %h expected %h", got, exp_v); end
        i_ps_on = 1'b0;
        sb.push_back(model(3'd0, 1'b0));
        tick(1);
        got = observe(); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL ps_off: got %h expected %h", got, exp_v); end
        i_ps_on = 1'b1;
        sb.push_back(model(3'd1, 1'b0));
        tick(16);
        got = observe(); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL restart_fan: got %h expected %h", got, exp_v); end
        sb.push_back(model(3'd2, 1'b0));
        tick(1);
        got = observe(); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL restart_caw: got %h expected %h", got, exp_v); end
    endtask

    initial begin
        #1;
        test_reset();
        test_powerup();
        test_hv_entry();
        test_trip();
        test_timeout();
        test_reset_mid_hv();
        test_ps_off_caw();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
